// File: rtl/gf_serial_mult.sv
// rtl/gf_serial_mult.sv - bit-serial GF(2^13) multiplier, p(x) = x^13 + x^4 + x^3 + x + 1
module gf_serial_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] a,
  input  logic [12:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [12:0] c
);

  localparam logic [12:0] RED = 13'h001B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [12:0] a_reg;
  logic [12:0] b_reg;
  logic [12:0] acc;
  logic [3:0]  cnt;
  logic [12:0] acc_shift;
  logic [12:0] acc_next;

  // Horner step, MSB of b first: shift-and-reduce, then add the partial product
  always_comb begin
    acc_shift = {acc[11:0], 1'b0} ^ (acc[12] ? RED : 13'h0000);
    acc_next  = acc_shift ^ (b_reg[cnt] ? a_reg : 13'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= 13'h0000;
      acc   <= 13'h0000;
      cnt   <= 4'd12;
      a_reg <= 13'h0000;
      b_reg <= 13'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= 13'h0000;
            cnt   <= 4'd12;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == 4'd0) begin
            c     <= acc_next;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_serial_mult.sv
// tb/tb_gf_serial_mult.sv - scoreboard bench for gf_serial_mult
module tb_gf_serial_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] a;
  logic [12:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [12:0] c;

  int total = 0;
  int bad = 0;
  int done_count = 0;

  logic [12:0] exp_q[$];
  logic [12:0] exp_c = 13'h0000;
  bit          hold_ok = 1'b0;
  bit          prev_rst = 1'b0;

  gf_serial_mult dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  always #5 clk = ~clk;

  // Schoolbook carry-free product followed by long division by p(x)
  function automatic logic [12:0] gf_ref(input logic [12:0] x, input logic [12:0] y);
    logic [24:0] p;
    p = 25'h0;
    for (int i = 0; i < 13; i++)
      if (y[i]) p = p ^ ({12'h0, x} << i);
    for (int k = 24; k >= 13; k--)
      if (p[k]) p = p ^ (25'h0000201B << (k - 13));
    return p[12:0];
  endfunction

  // Scoreboard: push on accept, pop on done, and c must hold between dones
  always @(negedge clk) begin
    if (prev_rst) begin
      exp_c   = 13'h0000;
      hold_ok = 1'b1;
    end
    if (done) begin
      done_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done c=%h with no operation pending", c);
      end else begin
        exp_c = exp_q.pop_front();
        if (c !== exp_c) begin
          bad++;
          $display("FAIL result c=%h expected=%h", c, exp_c);
        end
      end
    end else if (hold_ok) begin
      total++;
      if (c !== exp_c) begin
        bad++;
        $display("FAIL c_hold c=%h expected=%h", c, exp_c);
      end
    end
    if (rst) exp_q.delete();
    else if (ready && start) exp_q.push_back(gf_ref(a, b));
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [12:0] av, input logic [12:0] bv, output logic [12:0] cv);
    bit seen;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 13'($urandom);
    b = 13'($urandom);
    wait_done(seen);
    cv = c;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout a=%h b=%h", av, bv);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 13'h1234;
    b = 13'h0567;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || c !== 13'h0000) begin
      bad++;
      $display("FAIL reset_state ready=%b busy=%b done=%b c=%h expected 1 0 0 0000", ready, busy, done, c);
    end
    tick();
  endtask

  task automatic test_latency();
    int k;
    int bc;
    bit seen;
    a = 13'h0001;
    b = 13'h0002;
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    seen = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || k != 13) begin
      bad++;
      $display("FAIL done_latency seen=%b cycle=%0d expected cycle 13", seen, k);
    end
    total++;
    if (bc != 13) begin
      bad++;
      $display("FAIL busy_cycles got=%0d expected=13", bc);
    end
    total++;
    if (ready !== 1'b0 || busy !== 1'b0 || c !== 13'h0002) begin
      bad++;
      $display("FAIL done_cycle ready=%b busy=%b c=%h expected 0 0 0002", ready, busy, c);
    end
    tick();
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL back_to_idle ready=%b done=%b expected 1 0", ready, done);
    end
  endtask

  task automatic test_vectors();
    logic [12:0] va[4] = '{13'h1000, 13'h1000, 13'h1FFF, 13'h0003};
    logic [12:0] vb[4] = '{13'h0002, 13'h1000, 13'h0000, 13'h0003};
    logic [12:0] vc[4] = '{13'h001B, 13'h185A, 13'h0000, 13'h0005};
    logic [12:0] cv;
    int d0;
    for (int i = 0; i < 4; i++) begin
      d0 = done_count;
      run_op(va[i], vb[i], cv);
      total++;
      if (cv !== vc[i] || done_count != d0 + 1) begin
        bad++;
        $display("FAIL vector%0d c=%h dones=%0d expected c=%h dones=1", i, cv, done_count - d0, vc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    start = 1'b1;
    a = 13'($urandom);
    b = 13'($urandom);
    for (int cyc = 0; cyc < 75; cyc++) begin
      @(negedge clk);
      if (done) times.push_back(cyc);
      @(posedge clk);
      #1;
      a = 13'($urandom);
      b = 13'($urandom);
    end
    start = 1'b0;
    total++;
    if (times.size() != 5) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d expected=5", times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      total++;
      if (times[i] - times[i-1] != 15) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d expected=15", times[i] - times[i-1]);
      end
    end
    repeat (20) tick();
  endtask

  task automatic test_mid_reset();
    int d0;
    logic [12:0] cv;
    a = 13'h0ABC;
    b = 13'h1DEF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    d0 = done_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || c !== 13'h0000) begin
      bad++;
      $display("FAIL mid_reset ready=%b busy=%b done=%b c=%h expected 1 0 0 0000", ready, busy, done, c);
    end
    repeat (20) tick();
    total++;
    if (done_count != d0) begin
      bad++;
      $display("FAIL mid_reset_no_done dones=%0d expected=0", done_count - d0);
    end
    run_op(13'h0ABC, 13'h1DEF, cv);
    total++;
    if (cv !== gf_ref(13'h0ABC, 13'h1DEF)) begin
      bad++;
      $display("FAIL after_reset c=%h expected=%h", cv, gf_ref(13'h0ABC, 13'h1DEF));
    end
  endtask

  task automatic test_random();
    bit seen;
    for (int i = 0; i < 3000; i++) begin
      a = 13'($urandom);
      b = 13'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      if ($urandom_range(7) == 0) begin
        repeat ($urandom_range(16)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        wait_done(seen);
        total++;
        if (!seen) begin
          bad++;
          $display("FAIL random_timeout op=%0d", i);
        end
        tick();
      end
    end
    repeat (20) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_results got=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 13'h0000;
    b = 13'h0000;
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
